multicycle_control: RTL and testbench

- Main control FSM for the multicycle MIPS core.
- Sequences fetch, decode, execute, memory and writeback.
- Drives every datapath select and strobe, including the RegDst select of the 5-bit destination-register mux, the PC/memory/ALU source muxes, and all write enables.
- Memory accesses use a ready handshake so wait states stall the sequence.

---
 rtl/multicycle_control.sv | 242 ++++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS core: fetch, decode, execute, memory, writeback.
// Optional macro MC_BNE_EN adds branch-not-equal support through a latched BranchNe flag.
module multicycle_control (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Opcode,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       InstrDone,
    output logic       IllegalOp,
    output logic [3:0] State
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`ifdef MC_BNE_EN
    localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    state_t r_state;
    state_t w_next;
    logic   w_illegal;
    logic   w_taken;

    logic       w_pc_write;
    logic       w_pc_write_cond;
    logic       w_iord;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_memto_reg;
    logic       w_reg_dst;
    logic       w_reg_write;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [1:0] w_alu_op;
    logic [1:0] w_pc_source;
    logic       w_instr_done;

`ifdef MC_BNE_EN
    logic r_branch_ne;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= S_FETCH;
`ifdef MC_BNE_EN
            r_branch_ne <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
`ifdef MC_BNE_EN
            if (r_state == S_DECODE) begin
                r_branch_ne <= (Opcode == OP_BNE);
            end
`endif
        end
    end

    // Next state; IllegalOp is a Mealy-style pulse in the cycle that abandons the instruction.
    always_comb begin
        w_next    = S_FETCH;
        w_illegal = 1'b0;
        case (r_state)
            S_FETCH:  w_next = MemReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
`ifdef MC_BNE_EN
                    OP_BNE:       w_next = S_BRANCH;
`endif
                    OP_J:         w_next = S_JUMP;
                    OP_ADDI:      w_next = S_ADDIEX;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (Opcode == OP_LW) begin
                    w_next = S_MEMRD;
                end else if (Opcode == OP_SW) begin
                    w_next = S_MEMWR;
                end else begin
                    w_next    = S_FETCH;
                    w_illegal = 1'b1;
                end
            end
            S_MEMRD:  w_next = MemReady ? S_MEMWB : S_MEMRD;
            S_MEMWB:  w_next = S_FETCH;
            S_MEMWR:  w_next = MemReady ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            S_ALUWB:  w_next = S_FETCH;
            S_BRANCH: w_next = S_FETCH;
            S_JUMP:   w_next = S_FETCH;
            S_ADDIEX: w_next = S_ADDIWB;
            S_ADDIWB: w_next = S_FETCH;
            default: begin
                w_next    = S_FETCH;
                w_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_pc_write      = 1'b0;
        w_pc_write_cond = 1'b0;
        w_iord          = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_memto_reg     = 1'b0;
        w_reg_dst       = 1'b0;
        w_reg_write     = 1'b0;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_op        = 2'b00;
        w_pc_source     = 2'b00;
        w_instr_done    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_read  = 1'b1;
                w_alu_src_b = 2'b01;
                w_ir_write  = MemReady;
                w_pc_write  = MemReady;
            end
            S_DECODE: w_alu_src_b = 2'b11;
            S_MEMADR: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                w_mem_read = 1'b1;
                w_iord     = 1'b1;
            end
            S_MEMWB: begin
                w_memto_reg  = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWR: begin
                w_mem_write  = 1'b1;
                w_iord       = 1'b1;
                w_instr_done = MemReady;
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_op    = 2'b10;
            end
            S_ALUWB: begin
                w_reg_dst    = 1'b1;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a     = 1'b1;
                w_alu_op        = 2'b01;
                w_pc_source     = 2'b01;
                w_pc_write_cond = 1'b1;
                w_instr_done    = 1'b1;
            end
            S_JUMP: begin
                w_pc_source  = 2'b10;
                w_pc_write   = 1'b1;
                w_instr_done = 1'b1;
            end
            S_ADDIEX: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'b10;
            end
            S_ADDIWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            default: begin
                w_pc_write = 1'b0;
            end
        endcase
    end

`ifdef MC_BNE_EN
    assign w_taken = Zero ^ r_branch_ne;
`else
    assign w_taken = Zero;
`endif

    // State-changing strobes are gated by Reset so a reset mid-instruction corrupts nothing.
    assign PCWrite     = w_pc_write & ~Reset;
    assign PCEn        = (w_pc_write | (w_pc_write_cond & w_taken)) & ~Reset;
    assign IRWrite     = w_ir_write & ~Reset;
    assign MemWrite    = w_mem_write & ~Reset;
    assign RegWrite    = w_reg_write & ~Reset;
    assign PCWriteCond = w_pc_write_cond;
    assign IorD        = w_iord;
    assign MemRead     = w_mem_read;
    assign MemtoReg    = w_memto_reg;
    assign RegDst      = w_reg_dst;
    assign ALUSrcA     = w_alu_src_a;
    assign ALUSrcB     = w_alu_src_b;
    assign ALUOp       = w_alu_op;
    assign PCSource    = w_pc_source;
    assign InstrDone   = w_instr_done;
    assign IllegalOp   = w_illegal;
    assign State       = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction cycle paths from the instruction semantics,
// compared cycle by cycle against every control output.
module tb_multicycle_control;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam int W = 23;

    logic       Clk;
    logic       Reset;
    logic [5:0] Opcode;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, InstrDone, IllegalOp;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] expr_q[$];
    bit           mr_q[$];

    multicycle_control dut (
        .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCEn(PCEn), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
        .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCSource(PCSource), .InstrDone(InstrDone), .IllegalOp(IllegalOp),
        .State(State)
    );

    logic [W-1:0] w_act;
    assign w_act = {State, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, PCEn, RegWrite,
                    RegDst, MemtoReg, InstrDone, IllegalOp, IorD, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic bit is_legal(input logic [5:0] op);
        bit ok;
        ok = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
             (op == OP_J) || (op == OP_ADDI);
`ifdef MC_BNE_EN
        ok = ok || (op == OP_BNE);
`endif
        return ok;
    endfunction

    // Required control word for one cycle spent in state st (spec state numbers).
    function automatic logic [W-1:0] exp_vec(input int st, input bit mr, input bit take,
                                              input bit ill, input bit rst);
        logic mrd = 0, mw = 0, irw = 0, pcw = 0, pwc = 0, pcen = 0, rw = 0, rdst = 0;
        logic m2r = 0, done = 0, ilg = 0, iord = 0, srca = 0;
        logic [1:0] srcb = 0, aluop = 0, pcs = 0;
        case (st)
            0:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            1:  begin srcb = 2'b11; ilg = ill; end
            2:  begin srca = 1; srcb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin m2r = 1; rw = 1; done = 1; end
            5:  begin mw = 1; iord = 1; done = mr; end
            6:  begin srca = 1; aluop = 2'b10; end
            7:  begin rdst = 1; rw = 1; done = 1; end
            8:  begin srca = 1; aluop = 2'b01; pcs = 2'b01; pwc = 1; done = 1; end
            9:  begin pcs = 2'b10; pcw = 1; done = 1; end
            10: begin srca = 1; srcb = 2'b10; end
            11: begin rw = 1; done = 1; end
            default: ilg = 1;
        endcase
        pcen = pcw | ((st == 8) && take);
        if (rst) begin
            pcw = 0; pcen = 0; irw = 0; mw = 0; rw = 0;
        end
        return {4'(st), mrd, mw, irw, pcw, pwc, pcen, rw, rdst, m2r, done, ilg, iord, srca,
                srcb, aluop, pcs};
    endfunction

    task automatic push(input int st, input bit mr, input bit take, input bit ill);
        exp_q.push_back(exp_vec(st, mr, take, ill, 1'b0));
        expr_q.push_back(exp_vec(st, mr, take, ill, 1'b1));
        mr_q.push_back(mr);
    endtask

    // Cycle path of one instruction: fetch stalls, decode, then the opcode's own phases.
    task automatic build(input logic [5:0] op, input bit z, input int fstall, input int mstall);
        bit ill;
        exp_q.delete(); expr_q.delete(); mr_q.delete();
        for (int i = 0; i < fstall; i++) push(0, 1'b0, 1'b0, 1'b0);
        push(0, 1'b1, 1'b0, 1'b0);
        ill = !is_legal(op);
        push(1, 1'($urandom_range(0, 1)), 1'b0, ill);
        if (!ill) begin
            case (op)
                OP_LW: begin
                    push(2, 1'($urandom_range(0, 1)), 0, 0);
                    for (int i = 0; i < mstall; i++) push(3, 1'b0, 0, 0);
                    push(3, 1'b1, 0, 0);
                    push(4, 1'($urandom_range(0, 1)), 0, 0);
                end
                OP_SW: begin
                    push(2, 1'($urandom_range(0, 1)), 0, 0);
                    for (int i = 0; i < mstall; i++) push(5, 1'b0, 0, 0);
                    push(5, 1'b1, 0, 0);
                end
                OP_RTYPE: begin
                    push(6, 1'($urandom_range(0, 1)), 0, 0);
                    push(7, 1'($urandom_range(0, 1)), 0, 0);
                end
                OP_BEQ: push(8, 1'($urandom_range(0, 1)), z, 0);
                OP_BNE: push(8, 1'($urandom_range(0, 1)), !z, 0);
                OP_J:   push(9, 1'($urandom_range(0, 1)), 0, 0);
                OP_ADDI: begin
                    push(10, 1'($urandom_range(0, 1)), 0, 0);
                    push(11, 1'($urandom_range(0, 1)), 0, 0);
                end
                default: ;
            endcase
        end
    endtask

    // Drive the built path; at step cut (if >= 0) Reset is raised for two cycles.
    task automatic run_path(input string name, input logic [5:0] op, input bit z, input int cut);
        logic [W-1:0] e;
        Opcode = op;
        Zero   = z;
        for (int i = 0; i < exp_q.size(); i++) begin
            MemReady = mr_q[i];
            if (i == cut) Reset = 1'b1;
            @(negedge Clk);
            e = (i == cut) ? expr_q[i] : exp_q[i];
            checks++;
            if (w_act !== e) begin
                errors++;
                $display("FAIL %s step=%0d state=%0d act=%h exp=%h", name, i, State, w_act, e);
            end
            @(posedge Clk); #1;
            if (i == cut) begin
                @(negedge Clk);
                e = exp_vec(0, mr_q[i], 1'b0, 1'b0, 1'b1);
                checks++;
                if (w_act !== e) begin
                    errors++;
                    $display("FAIL %s_in_reset act=%h exp=%h", name, w_act, e);
                end
                @(posedge Clk); #1;
                Reset = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        logic [W-1:0] e;
        Reset = 1'b1; MemReady = 1'b1; Opcode = OP_RTYPE; Zero = 1'b0;
        @(posedge Clk); #1;
        @(negedge Clk);
        e = exp_vec(0, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (w_act !== e) begin
            errors++;
            $display("FAIL reset_state act=%h exp=%h", w_act, e);
        end
        @(posedge Clk); #1;
        Reset = 1'b0;
        build(OP_RTYPE, 1'b0, 0, 0);
        run_path("reset_mid_exec", OP_RTYPE, 1'b0, 2);
        build(OP_RTYPE, 1'b0, 0, 0);
        run_path("reset_in_aluwb", OP_RTYPE, 1'b0, 3);
        build(OP_J, 1'b0, 0, 0);
        run_path("reset_in_jump", OP_J, 1'b0, 2);
        build(OP_SW, 1'b0, 0, 1);
        run_path("reset_in_memwr", OP_SW, 1'b0, 3);
        build(OP_LW, 1'b0, 0, 0);
        run_path("reset_in_memwb", OP_LW, 1'b0, 4);
        build(OP_ADDI, 1'b0, 0, 0);
        run_path("reset_in_fetch", OP_ADDI, 1'b0, 0);
    endtask

    task automatic test_lw;
        build(OP_LW, 1'b0, 0, 0);
        run_path("lw", OP_LW, 1'b0, -1);
    endtask

    task automatic test_rtype_fetch_stall;
        build(OP_RTYPE, 1'b0, 3, 0);
        run_path("rtype_fetch_stall", OP_RTYPE, 1'b0, -1);
    endtask

    task automatic test_sw_mem_stall;
        build(OP_SW, 1'b0, 0, 2);
        run_path("sw_mem_stall", OP_SW, 1'b0, -1);
    endtask

    task automatic test_beq;
        build(OP_BEQ, 1'b1, 0, 0);
        run_path("beq_taken", OP_BEQ, 1'b1, -1);
        build(OP_BEQ, 1'b0, 0, 0);
        run_path("beq_not_taken", OP_BEQ, 1'b0, -1);
    endtask

    task automatic test_illegal;
        build(6'b111111, 1'b0, 0, 0);
        run_path("illegal_3f", 6'b111111, 1'b0, -1);
        build(OP_BNE, 1'b0, 0, 0);
        run_path("bne_zero0", OP_BNE, 1'b0, -1);
        build(OP_BNE, 1'b1, 0, 0);
        run_path("bne_zero1", OP_BNE, 1'b1, -1);
    endtask

    task automatic test_jump_addi;
        build(OP_J, 1'b0, 1, 0);
        run_path("jump", OP_J, 1'b0, -1);
        build(OP_ADDI, 1'b1, 0, 0);
        run_path("addi", OP_ADDI, 1'b1, -1);
    endtask

    task automatic test_back_to_back;
        logic [5:0] ops[7];
        logic [5:0] op;
        bit         z;
        ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_BNE};
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 7) op = 6'($urandom);
            else op = ops[$urandom_range(0, 6)];
            z = 1'($urandom_range(0, 1));
            build(op, z, $urandom_range(0, 3), $urandom_range(0, 3));
            run_path("random", op, z, -1);
        end
    endtask

    initial begin
        test_reset;
        test_lw;
        test_rtype_fetch_stall;
        test_sw_mem_stall;
        test_beq;
        test_illegal;
        test_jump_addi;
        test_back_to_back;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
